// File: rtl/decode_pkg.sv
// decode_pkg: encodings shared by the decode stage and its register file.
//   br_type_e  - branch/jump condition selector
//   a3_sel_e   - destination register selector
//   ext_sel_e  - immediate extension selector
//   NOP        - instruction word loaded into E on a bubble
package decode_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_J    = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    A3_RT   = 2'b00,
    A3_RD   = 2'b01,
    A3_R31  = 2'b10,
    A3_NONE = 2'b11
  } a3_sel_e;

  typedef enum logic [1:0] {
    EXT_SIGN = 2'b00,
    EXT_ZERO = 2'b01,
    EXT_LUI  = 2'b10,
    EXT_RSVD = 2'b11
  } ext_sel_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam int          LINK_REG = 31;

  // Word-aligned branch displacement from a 16-bit immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/decode_stage_param_regfile_wt.sv
// regfile_wt: NREG x XLEN register file, two read ports, one write port.
//   clk, reset        - clock, synchronous active-high reset (clears all entries)
//   i_we/i_waddr/i_wdata - write port (writes to entry 0 are dropped)
//   i_raddr1/2        - read addresses
//   o_rdata1/2        - read data; entry 0 reads zero, a read of the address being
//                       written this cycle returns the incoming write data
module regfile_wt #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  // Flop array rather than RAM: every entry must clear on reset and both
  // read ports are asynchronous.
  logic [XLEN-1:0] r_mem [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    if (addr == '0) begin
      return '0;
    end else if (i_we && (addr == i_waddr)) begin
      return i_wdata;
    end else begin
      return r_mem[addr];
    end
  endfunction

  assign o_rdata1 = read_port(i_raddr1);
  assign o_rdata2 = read_port(i_raddr2);

endmodule

// File: rtl/decode_stage_param.sv
// decode_stage_param: MIPS decode stage with register file, operand forwarding,
// branch resolution, next-PC generation and the D/E pipeline register.
//   clk, reset             - clock, synchronous active-high reset
//   instr_i, pc_i, valid_i - instruction in D
//   hold_i, bubble_i       - D/E register keep / insert-NOP controls (hold wins)
//   wb_*                   - write port from W (wb_pc feeds only the simulation trace)
//   fwd_data, fwd_sel1/2   - external forward sources and rs/rt selects
//   a3_sel, ext_sel, br_type, jr_i, gen_we - control decoded for this instruction
//   npc_o, taken_o, rs_val_o - combinational outputs
//   e_*                    - registered D/E outputs
// XLEN must be at least 32 (jr targets are taken from rs[31:0]).
module decode_stage_param
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NFWD = 2,
  parameter int SW   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          instr_i,
  input  logic [31:0]          pc_i,
  input  logic                 valid_i,
  input  logic                 hold_i,
  input  logic                 bubble_i,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [31:0]          wb_pc,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic [SW-1:0]        fwd_sel1,
  input  logic [SW-1:0]        fwd_sel2,
  input  logic [1:0]           a3_sel,
  input  logic [1:0]           ext_sel,
  input  logic [2:0]           br_type,
  input  logic                 jr_i,
  input  logic                 gen_we,
  output logic [31:0]          npc_o,
  output logic                 taken_o,
  output logic [XLEN-1:0]      rs_val_o,
  output logic                 e_valid,
  output logic [31:0]          e_pc,
  output logic [31:0]          e_instr,
  output logic [XLEN-1:0]      e_rs,
  output logic [XLEN-1:0]      e_rt,
  output logic [XLEN-1:0]      e_imm,
  output logic [AW-1:0]        e_a3,
  output logic                 e_we
);

  // ---------------- field extraction ----------------
  logic [AW-1:0] w_rs_addr, w_rt_addr, w_rd_addr;
  logic [15:0]   w_imm16;

  assign w_rs_addr = AW'(instr_i[25:21]);
  assign w_rt_addr = AW'(instr_i[20:16]);
  assign w_rd_addr = AW'(instr_i[15:11]);
  assign w_imm16   = instr_i[15:0];

  // wb_pc is carried only for the simulation write trace.
  logic w_unused_wb_pc;
  assign w_unused_wb_pc = ^wb_pc;

  // ---------------- register file ----------------
  logic [XLEN-1:0] w_rf_rs, w_rf_rt;

  regfile_wt #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_we),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs_addr),
    .i_raddr2 (w_rt_addr),
    .o_rdata1 (w_rf_rs),
    .o_rdata2 (w_rf_rt)
  );

  // ---------------- forwarding ----------------
  logic [XLEN-1:0] w_fwd_src [NFWD];

  genvar gi;
  generate
    for (gi = 0; gi < NFWD; gi++) begin : g_fwd_unpack
      assign w_fwd_src[gi] = fwd_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Select 0 and any select beyond the last source fall back to the regfile.
  logic [XLEN-1:0] w_rs_val, w_rt_val;

  always_comb begin
    w_rs_val = w_rf_rs;
    w_rt_val = w_rf_rt;
    for (int k = 0; k < NFWD; k++) begin
      if (fwd_sel1 == SW'(k + 1)) w_rs_val = w_fwd_src[k];
      if (fwd_sel2 == SW'(k + 1)) w_rt_val = w_fwd_src[k];
    end
  end

  assign rs_val_o = w_rs_val;

  // ---------------- branch condition ----------------
  logic w_rs_zero, w_rs_neg, w_eq, w_cond;

  assign w_rs_zero = (w_rs_val == '0);
  assign w_rs_neg  = w_rs_val[XLEN-1];
  assign w_eq      = (w_rs_val == w_rt_val);

  always_comb begin
    w_cond = 1'b0;
    if (jr_i) begin
      w_cond = 1'b1;
    end else begin
      case (br_type_e'(br_type))
        BR_BEQ:  w_cond = w_eq;
        BR_BNE:  w_cond = !w_eq;
        BR_BLEZ: w_cond = w_rs_neg || w_rs_zero;
        BR_BGTZ: w_cond = !w_rs_neg && !w_rs_zero;
        BR_BLTZ: w_cond = w_rs_neg;
        BR_BGEZ: w_cond = !w_rs_neg;
        BR_J:    w_cond = 1'b1;
        default: w_cond = 1'b0;
      endcase
    end
  end

  // ---------------- next PC ----------------
  // One delay slot: the fall-through fetch is the instruction after the slot.
  logic [31:0] w_pc_plus4, w_pc_plus8, w_br_tgt, w_j_tgt, w_tgt;

  assign w_pc_plus4 = pc_i + 32'd4;
  assign w_pc_plus8 = pc_i + 32'd8;
  assign w_br_tgt   = w_pc_plus4 + branch_offset(w_imm16);
  assign w_j_tgt    = {w_pc_plus4[31:28], instr_i[25:0], 2'b00};

  always_comb begin
    w_tgt = w_br_tgt;
    if (jr_i) begin
      w_tgt = w_rs_val[31:0];
    end else if (br_type_e'(br_type) == BR_J) begin
      w_tgt = w_j_tgt;
    end
  end

  assign taken_o = valid_i && w_cond;
  assign npc_o   = taken_o ? w_tgt : w_pc_plus8;

  // ---------------- immediate / link value ----------------
  logic [XLEN-1:0] w_ext, w_imm_next;

  always_comb begin
    w_ext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
    case (ext_sel_e'(ext_sel))
      EXT_ZERO: w_ext = {{(XLEN-16){1'b0}}, w_imm16};
      EXT_LUI:  w_ext = XLEN'({w_imm16, 16'h0000});
      default:  w_ext = {{(XLEN-16){w_imm16[15]}}, w_imm16};
    endcase
  end

  // Link instructions carry their return address to E in the immediate slot.
  assign w_imm_next = (a3_sel_e'(a3_sel) == A3_R31) ? XLEN'(w_pc_plus8) : w_ext;

  // ---------------- destination ----------------
  logic [AW-1:0] w_a3;
  logic          w_we_next;

  always_comb begin
    w_a3 = '0;
    case (a3_sel_e'(a3_sel))
      A3_RT:   w_a3 = w_rt_addr;
      A3_RD:   w_a3 = w_rd_addr;
      A3_R31:  w_a3 = AW'(LINK_REG);
      default: w_a3 = '0;
    endcase
  end

  assign w_we_next = gen_we && (w_a3 != '0) && (a3_sel_e'(a3_sel) != A3_NONE);

  // ---------------- D/E register ----------------
  logic            r_e_valid;
  logic [31:0]     r_e_pc, r_e_instr;
  logic [XLEN-1:0] r_e_rs, r_e_rt, r_e_imm;
  logic [AW-1:0]   r_e_a3;
  logic            r_e_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_valid <= 1'b0;
      r_e_pc    <= '0;
      r_e_instr <= NOP;
      r_e_rs    <= '0;
      r_e_rt    <= '0;
      r_e_imm   <= '0;
      r_e_a3    <= '0;
      r_e_we    <= 1'b0;
    end else if (hold_i) begin
      // E is stalled: keep everything, even if a bubble is also requested.
    end else if (bubble_i || !valid_i) begin
      r_e_valid <= 1'b0;
      r_e_pc    <= '0;
      r_e_instr <= NOP;
      r_e_rs    <= '0;
      r_e_rt    <= '0;
      r_e_imm   <= '0;
      r_e_a3    <= '0;
      r_e_we    <= 1'b0;
    end else begin
      r_e_valid <= 1'b1;
      r_e_pc    <= pc_i;
      r_e_instr <= instr_i;
      r_e_rs    <= w_rs_val;
      r_e_rt    <= w_rt_val;
      r_e_imm   <= w_imm_next;
      r_e_a3    <= w_a3;
      r_e_we    <= w_we_next;
    end
  end

  assign e_valid = r_e_valid;
  assign e_pc    = r_e_pc;
  assign e_instr = r_e_instr;
  assign e_rs    = r_e_rs;
  assign e_rt    = r_e_rt;
  assign e_imm   = r_e_imm;
  assign e_a3    = r_e_a3;
  assign e_we    = r_e_we;

endmodule

// File: tb/tb_decode_stage_param.sv
module tb_decode_stage_param;

  logic        clk = 1'b0;
  logic        reset, valid_i, hold_i, bubble_i, wb_we, jr_i, gen_we;
  logic [31:0] instr_i, pc_i, wb_data, wb_pc;
  logic [4:0]  wb_addr;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_sel1, fwd_sel2, a3_sel, ext_sel;
  logic [2:0]  br_type;
  logic [31:0] npc_o, rs_val_o, e_pc, e_instr, e_rs, e_rt, e_imm;
  logic        taken_o, e_valid, e_we;
  logic [4:0]  e_a3;

  logic [31:0] fwd_arr [2];
  assign fwd_data = {fwd_arr[1], fwd_arr[0]};

  always #5 clk = ~clk;

  decode_stage_param dut (
    .clk(clk), .reset(reset), .instr_i(instr_i), .pc_i(pc_i), .valid_i(valid_i),
    .hold_i(hold_i), .bubble_i(bubble_i), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_pc(wb_pc), .fwd_data(fwd_data), .fwd_sel1(fwd_sel1),
    .fwd_sel2(fwd_sel2), .a3_sel(a3_sel), .ext_sel(ext_sel), .br_type(br_type),
    .jr_i(jr_i), .gen_we(gen_we), .npc_o(npc_o), .taken_o(taken_o),
    .rs_val_o(rs_val_o), .e_valid(e_valid), .e_pc(e_pc), .e_instr(e_instr),
    .e_rs(e_rs), .e_rt(e_rt), .e_imm(e_imm), .e_a3(e_a3), .e_we(e_we)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, instr, rs, rt, imm;
    logic [4:0]  a3;
    logic        we;
  } e_t;

  logic [31:0] m_regs [32];
  e_t          m_e;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_we && a == wb_addr) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_opnd(input logic [1:0] sel, input logic [4:0] a);
    if (sel == 2'd1) return fwd_arr[0];
    if (sel == 2'd2) return fwd_arr[1];
    return m_read(a);
  endfunction

  function automatic logic m_taken();
    logic [31:0] rs, rt;
    int          srs;
    logic        c;
    rs  = m_opnd(fwd_sel1, instr_i[25:21]);
    rt  = m_opnd(fwd_sel2, instr_i[20:16]);
    srs = $signed(rs);
    if (jr_i) c = 1'b1;
    else case (br_type)
      3'd1: c = (rs == rt);
      3'd2: c = (rs != rt);
      3'd3: c = (srs <= 0);
      3'd4: c = (srs > 0);
      3'd5: c = (srs < 0);
      3'd6: c = (srs >= 0);
      3'd7: c = 1'b1;
      default: c = 1'b0;
    endcase
    return valid_i && c;
  endfunction

  function automatic logic [31:0] m_npc();
    int          off;
    logic [31:0] p4;
    if (!m_taken()) return pc_i + 32'd8;
    p4 = pc_i + 32'd4;
    if (jr_i) return m_opnd(fwd_sel1, instr_i[25:21]);
    if (br_type == 3'd7) return {p4[31:28], instr_i[25:0], 2'b00};
    off = $signed(instr_i[15:0]);
    return p4 + off * 4;
  endfunction

  function automatic e_t m_load();
    e_t   e;
    int   simm;
    e.valid = 1'b1;
    e.pc    = pc_i;
    e.instr = instr_i;
    e.rs    = m_opnd(fwd_sel1, instr_i[25:21]);
    e.rt    = m_opnd(fwd_sel2, instr_i[20:16]);
    simm    = $signed(instr_i[15:0]);
    if (a3_sel == 2'd2)      e.imm = pc_i + 32'd8;
    else if (ext_sel == 2'd1) e.imm = {16'h0, instr_i[15:0]};
    else if (ext_sel == 2'd2) e.imm = instr_i[15:0] * 32'd65536;
    else                      e.imm = simm;
    case (a3_sel)
      2'd0: e.a3 = instr_i[20:16];
      2'd1: e.a3 = instr_i[15:11];
      2'd2: e.a3 = 5'd31;
      default: e.a3 = 5'd0;
    endcase
    e.we = gen_we && (e.a3 != 0) && (a3_sel != 2'd3);
    return e;
  endfunction

  // One clock: check combinational outputs, advance model and DUT, check D/E.
  task automatic step();
    e_t nxt;
    #1;
    chk("taken_o", {31'h0, taken_o}, {31'h0, m_taken()});
    chk("npc_o", npc_o, m_npc());
    chk("rs_val_o", rs_val_o, m_opnd(fwd_sel1, instr_i[25:21]));
    nxt = m_load();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_e = '0;
    end else begin
      if (wb_we && wb_addr != 0) begin
        m_regs[wb_addr] = wb_data;
        $display("%0t@%h: $%0d <= %h", $time, wb_pc, wb_addr, wb_data);
      end
      if (!hold_i) m_e = (bubble_i || !valid_i) ? e_t'(0) : nxt;
    end
    #1;
    chk("e_valid", {31'h0, e_valid}, {31'h0, m_e.valid});
    chk("e_pc", e_pc, m_e.pc);
    chk("e_instr", e_instr, m_e.instr);
    chk("e_rs", e_rs, m_e.rs);
    chk("e_rt", e_rt, m_e.rt);
    chk("e_imm", e_imm, m_e.imm);
    chk("e_a3", {27'h0, e_a3}, {27'h0, m_e.a3});
    chk("e_we", {31'h0, e_we}, {31'h0, m_e.we});
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 0; valid_i = 0; hold_i = 0; bubble_i = 0; wb_we = 0; jr_i = 0; gen_we = 0;
    instr_i = 0; pc_i = 0; wb_data = 0; wb_pc = 0; wb_addr = 0;
    fwd_sel1 = 0; fwd_sel2 = 0; a3_sel = 0; ext_sel = 0; br_type = 0;
    fwd_arr[0] = 0; fwd_arr[1] = 0;
  endtask

  // ---------------- branch vector table ----------------
  typedef struct {
    logic [31:0] instr, pc;
    logic [2:0]  br;
    logic        jr, valid;
    logic [31:0] rs, rt;
    logic        taken;
    logic [31:0] npc;
  } vec_t;

  vec_t tbl [15];

  initial begin
    tbl[0]  = '{32'h10000004, 32'h1000, 3'd1, 1'b0, 1'b1, 32'd5, 32'd5, 1'b1, 32'h1014};
    tbl[1]  = '{32'h10000004, 32'h1000, 3'd1, 1'b0, 1'b1, 32'd5, 32'd6, 1'b0, 32'h1008};
    tbl[2]  = '{32'h10000004, 32'h1000, 3'd2, 1'b0, 1'b1, 32'd5, 32'd6, 1'b1, 32'h1014};
    tbl[3]  = '{32'h1000FFFE, 32'h2000, 3'd3, 1'b0, 1'b1, 32'd0, 32'd9, 1'b1, 32'h1FFC};
    tbl[4]  = '{32'h1000FFFE, 32'h2000, 3'd3, 1'b0, 1'b1, 32'd1, 32'd9, 1'b0, 32'h2008};
    tbl[5]  = '{32'h10000010, 32'h2000, 3'd4, 1'b0, 1'b1, 32'h7FFFFFFF, 32'd0, 1'b1, 32'h2044};
    tbl[6]  = '{32'h10000010, 32'h2000, 3'd4, 1'b0, 1'b1, 32'h80000000, 32'd0, 1'b0, 32'h2008};
    tbl[7]  = '{32'h1000FFFF, 32'h3000, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'd0, 1'b1, 32'h3000};
    tbl[8]  = '{32'h1000FFFF, 32'h3000, 3'd5, 1'b0, 1'b1, 32'd1, 32'd0, 1'b0, 32'h3008};
    tbl[9]  = '{32'h10000002, 32'h4000, 3'd6, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 32'h400C};
    tbl[10] = '{32'h10000002, 32'h4000, 3'd6, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h4008};
    tbl[11] = '{32'h0C000C01, 32'h3010, 3'd7, 1'b0, 1'b1, 32'd0, 32'd0, 1'b1, 32'h3004};
    tbl[12] = '{32'h00000008, 32'h5000, 3'd0, 1'b1, 1'b1, 32'h12345678, 32'd0, 1'b1, 32'h12345678};
    tbl[13] = '{32'h10000004, 32'h6000, 3'd0, 1'b0, 1'b1, 32'd5, 32'd5, 1'b0, 32'h6008};
    tbl[14] = '{32'h10000004, 32'h1000, 3'd1, 1'b0, 1'b0, 32'd5, 32'd5, 1'b0, 32'h1008};

    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_e = '0;
    idle();
    @(negedge clk);
    reset = 1;
    step();
    step();
    reset = 0;
    chk("reset_e_pc", e_pc, 32'h0);

    // Table: operands injected through forward sources 1 and 2.
    for (int i = 0; i < 15; i++) begin
      idle();
      instr_i = tbl[i].instr; pc_i = tbl[i].pc; br_type = tbl[i].br;
      jr_i = tbl[i].jr; valid_i = tbl[i].valid;
      fwd_sel1 = 2'd1; fwd_sel2 = 2'd2;
      fwd_arr[0] = tbl[i].rs; fwd_arr[1] = tbl[i].rt;
      #1;
      chk($sformatf("tbl%0d_taken", i), {31'h0, taken_o}, {31'h0, tbl[i].taken});
      chk($sformatf("tbl%0d_npc", i), npc_o, tbl[i].npc);
      step();
    end

    // Write-through then registered read of $5.
    idle();
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF; wb_pc = 32'h400;
    instr_i = {6'h0, 5'd5, 5'd0, 16'h0};
    #1 chk("wt_same_cycle", rs_val_o, 32'hDEADBEEF);
    step();
    wb_we = 0;
    #1 chk("wt_next_cycle", rs_val_o, 32'hDEADBEEF);
    step();

    // $0 stays zero; forward source 2 selected.
    idle();
    wb_we = 1; wb_addr = 0; wb_data = 32'h1234;
    #1 chk("r0_read", rs_val_o, 32'h0);
    step();
    idle();
    fwd_sel1 = 2'd2; fwd_arr[1] = 32'h55;
    #1 chk("fwd_src2", rs_val_o, 32'h55);
    step();
    fwd_sel1 = 2'd3; instr_i = {6'h0, 5'd5, 5'd0, 16'h0};
    #1 chk("fwd_sel_oob", rs_val_o, 32'hDEADBEEF);
    step();

    // jal into D/E, then hold+bubble, then bubble.
    idle();
    instr_i = 32'h0C000C01; pc_i = 32'h3010; valid_i = 1; br_type = 3'd7;
    a3_sel = 2'd2; gen_we = 1;
    #1 chk("jal_npc", npc_o, 32'h3004);
    step();
    chk("jal_e_a3", {27'h0, e_a3}, 32'd31);
    chk("jal_e_imm", e_imm, 32'h3018);
    chk("jal_e_we", {31'h0, e_we}, 32'd1);
    instr_i = 32'h10000004; pc_i = 32'h7000; hold_i = 1; bubble_i = 1;
    step();
    chk("hold_e_pc", e_pc, 32'h3010);
    chk("hold_e_imm", e_imm, 32'h3018);
    hold_i = 0;
    step();
    chk("bubble_e_valid", {31'h0, e_valid}, 32'd0);
    chk("bubble_e_we", {31'h0, e_we}, 32'd0);

    // Reset mid-stream after writing $8.
    idle();
    wb_we = 1; wb_addr = 8; wb_data = 32'hCAFE0008; wb_pc = 32'h800;
    instr_i = {6'h0, 5'd8, 5'd8, 16'h0}; pc_i = 32'h900; valid_i = 1;
    step();
    wb_we = 0; reset = 1;
    step();
    reset = 0;
    #1;
    chk("rst_r8", rs_val_o, 32'h0);
    chk("rst_e_valid", {31'h0, e_valid}, 32'd0);
    chk("rst_e_pc", e_pc, 32'h0);
    step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom % 50) == 0;
      instr_i  = $urandom;
      if ($urandom % 2) instr_i[25:21] = 5'($urandom_range(0, 7));
      pc_i     = $urandom & 32'hFFFF_FFFC;
      valid_i  = ($urandom % 8) != 0;
      hold_i   = ($urandom % 6) == 0;
      bubble_i = ($urandom % 6) == 0;
      wb_we    = $urandom % 2;
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      wb_pc    = $urandom;
      fwd_arr[0] = ($urandom % 4 == 0) ? 32'h0 : $urandom;
      fwd_arr[1] = ($urandom % 4 == 0) ? fwd_arr[0] : $urandom;
      fwd_sel1 = 2'($urandom_range(0, 3));
      fwd_sel2 = 2'($urandom_range(0, 3));
      a3_sel   = 2'($urandom_range(0, 3));
      ext_sel  = 2'($urandom_range(0, 2));
      br_type  = 3'($urandom_range(0, 7));
      jr_i     = ($urandom % 8) == 0;
      gen_we   = $urandom % 2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
